fp_cmp_pipe: RTL

FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

---
 rtl/fp_cmp_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage pipelined floating-point comparator with valid/ready
// handshake on both sides. S1 registers the sign and magnitude comparisons;
// S2 registers the mode-selected outcome.
// Compile-time option: define FP_CMP_NAN_EN to treat NaN operands as unordered.
// Without it, NaN and infinity encodings are ordered like any other value.
module fp_cmp_pipe #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10,
  parameter int unsigned ID_W   = 4,
  localparam int unsigned W     = 1 + EXP_W + MANT_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [W-1:0]    operand_a_i,
  input  logic [W-1:0]    operand_b_i,
  input  logic [1:0]      mode_i,
  input  logic [ID_W-1:0] id_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            result_o,
  output logic            eq_o,
  output logic            unordered_o,
  output logic [ID_W-1:0] id_o
);

  localparam int unsigned MagW = EXP_W + MANT_W;

  // Stage 1 state
  logic            s1_valid_q;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            mag_gt_q, mag_gt_d;
  logic            mag_eq_q, mag_eq_d;
  logic            both_zero_q, both_zero_d;
  logic            nan_q, nan_d;
  logic [1:0]      mode_q;
  logic [ID_W-1:0] id_q;

  // Stage 2 state
  logic            s2_valid_q;
  logic            result_q, result_d;
  logic            eq_q, eq_d;
  logic            unord_q, unord_d;
  logic [ID_W-1:0] id_out_q;

  logic s1_load, s2_load;
  logic [MagW-1:0] mag_a, mag_b;

  // S1 drains into S2 whenever S2 is empty or its result is being taken.
  assign s2_load = s1_valid_q & (~s2_valid_q | ready_i);
  assign ready_o = ~s1_valid_q | ~s2_valid_q | ready_i;
  assign s1_load = valid_i & (~s1_valid_q | s2_load);

  assign mag_a = operand_a_i[MagW-1:0];
  assign mag_b = operand_b_i[MagW-1:0];

  // Stage 1 combinational: sign/magnitude comparison and special-value flags.
  always_comb begin
    sign_a_d    = operand_a_i[W-1];
    sign_b_d    = operand_b_i[W-1];
    mag_gt_d    = mag_a > mag_b;
    mag_eq_d    = mag_a == mag_b;
    both_zero_d = ~|mag_a & ~|mag_b;
`ifdef FP_CMP_NAN_EN
    nan_d = (&operand_a_i[W-2 -: EXP_W] & |operand_a_i[MANT_W-1:0]) |
            (&operand_b_i[W-2 -: EXP_W] & |operand_b_i[MANT_W-1:0]);
`else
    nan_d = 1'b0;
`endif
  end

  // Stage 2 combinational: resolve ordering from S1 flags and pick the mode.
  always_comb begin
    logic gt;
    logic eq;
    eq = both_zero_q | (mag_eq_q & (sign_a_q == sign_b_q));
    gt = 1'b0;
    if (both_zero_q) begin
      gt = 1'b0;
    end else if (sign_a_q != sign_b_q) begin
      gt = ~sign_a_q;
    end else if (!sign_a_q) begin
      gt = mag_gt_q;
    end else begin
      gt = ~mag_gt_q & ~mag_eq_q;
    end
    unique case (mode_q)
      2'b00:   result_d = gt;
      2'b01:   result_d = gt | eq;
      2'b10:   result_d = ~gt & ~eq;
      default: result_d = eq;
    endcase
    eq_d    = eq;
    unord_d = nan_q;
    if (nan_q) begin
      result_d = 1'b0;
      eq_d     = 1'b0;
    end
  end

  // Stage 1 register: occupancy plus comparison flags, mode and tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mag_gt_q    <= 1'b0;
      mag_eq_q    <= 1'b0;
      both_zero_q <= 1'b0;
      nan_q       <= 1'b0;
      mode_q      <= 2'b00;
      id_q        <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q  <= 1'b1;
        sign_a_q    <= sign_a_d;
        sign_b_q    <= sign_b_d;
        mag_gt_q    <= mag_gt_d;
        mag_eq_q    <= mag_eq_d;
        both_zero_q <= both_zero_d;
        nan_q       <= nan_d;
        mode_q      <= mode_i;
        id_q        <= id_i;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Stage 2 register: result held stable until the downstream accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      result_q   <= 1'b0;
      eq_q       <= 1'b0;
      unord_q    <= 1'b0;
      id_out_q   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        result_q   <= result_d;
        eq_q       <= eq_d;
        unord_q    <= unord_d;
        id_out_q   <= id_q;
      end else if (ready_i) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign valid_o     = s2_valid_q;
  assign result_o    = result_q;
  assign eq_o        = eq_q;
  assign unordered_o = unord_q;
  assign id_o        = id_out_q;

endmodule
